// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - shared opcode, funct, state, aluop and alucontrol encodings
package mips_mc_pkg;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_MEMADR  = 4'd2,
      S_MEMRD   = 4'd3,
      S_MEMWB   = 4'd4,
      S_MEMWR   = 4'd5,
      S_RTYPEEX = 4'd6,
      S_RTYPEWB = 4'd7,
      S_BEQEX   = 4'd8,
      S_ADDIEX  = 4'd9,
      S_ADDIWB  = 4'd10,
      S_JEX     = 4'd11,
      S_BNEEX   = 4'd12,
      S_HALT    = 4'd15
   } state_t;

endpackage

// File: rtl/mips_mc_aludec.sv
// rtl/mips_mc_aludec.sv - combinational aluop/funct to alucontrol decoder
module mips_mc_aludec
   import mips_mc_pkg::*;
(
   input  logic [1:0] aluop,
   input  logic [5:0] funct,
   output logic [2:0] alucontrol
);

   always_comb begin
      alucontrol = ALU_ADD;
      case (aluop)
         ALUOP_SUB: alucontrol = ALU_SUB;
         ALUOP_FUNCT: begin
            // unknown funct still adds so the R-type retires harmlessly
            case (funct)
               FN_SUB:  alucontrol = ALU_SUB;
               FN_AND:  alucontrol = ALU_AND;
               FN_OR:   alucontrol = ALU_OR;
               FN_SLT:  alucontrol = ALU_SLT;
               default: alucontrol = ALU_ADD;
            endcase
         end
         default: alucontrol = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM with wait states and retire counter
// Optional bne support when MIPS_MC_BNE_EN is defined.
module mips_multicycle_ctrl
   import mips_mc_pkg::*;
#(
   parameter int ICOUNT_W     = 32,
   parameter bit ILLEGAL_HALT = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [5:0]          op,
   input  logic [5:0]          funct,
   input  logic                zero,
   input  logic                mem_ready,
   output logic                pcen,
   output logic                irwrite,
   output logic                regwrite,
   output logic                memwrite,
   output logic                iord,
   output logic                alusrca,
   output logic [1:0]          alusrcb,
   output logic                memtoreg,
   output logic                regdst,
   output logic [1:0]          pcsrc,
   output logic [2:0]          alucontrol,
   output logic                instr_done,
   output logic [ICOUNT_W-1:0] icount,
   output logic                halted,
   output logic [3:0]          state_dbg
);

   state_t     state, state_next;
   logic       pcwrite, branch, branch_ne;
   logic       irwrite_s, regwrite_s, memwrite_s;
   logic [1:0] aluop;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= S_FETCH;
         icount <= '0;
      end else begin
         state <= state_next;
         if (instr_done) icount <= icount + ICOUNT_W'(1);
      end
   end

   always_comb begin
      state_next = state;
      pcwrite    = 1'b0;
      branch     = 1'b0;
      branch_ne  = 1'b0;
      irwrite_s  = 1'b0;
      regwrite_s = 1'b0;
      memwrite_s = 1'b0;
      iord       = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      memtoreg   = 1'b0;
      regdst     = 1'b0;
      pcsrc      = 2'b00;
      aluop      = ALUOP_ADD;
      instr_done = 1'b0;
      case (state)
         S_FETCH: begin
            alusrcb   = 2'b01;
            pcwrite   = mem_ready;
            irwrite_s = mem_ready;
            if (mem_ready) state_next = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (op)
               OP_LW, OP_SW: state_next = S_MEMADR;
               OP_RTYPE:     state_next = S_RTYPEEX;
               OP_BEQ:       state_next = S_BEQEX;
               OP_ADDI:      state_next = S_ADDIEX;
               OP_J:         state_next = S_JEX;
`ifdef MIPS_MC_BNE_EN
               OP_BNE:       state_next = S_BNEEX;
`endif
               default:      state_next = ILLEGAL_HALT ? S_HALT : S_FETCH;
            endcase
         end
         S_MEMADR: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            state_next = (op == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            iord = 1'b1;
            if (mem_ready) state_next = S_MEMWB;
         end
         S_MEMWB: begin
            regwrite_s = 1'b1;
            memtoreg   = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_MEMWR: begin
            iord       = 1'b1;
            memwrite_s = 1'b1;
            if (mem_ready) begin
               instr_done = 1'b1;
               state_next = S_FETCH;
            end
         end
         S_RTYPEEX: begin
            alusrca    = 1'b1;
            aluop      = ALUOP_FUNCT;
            state_next = S_RTYPEWB;
         end
         S_RTYPEWB: begin
            regwrite_s = 1'b1;
            regdst     = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_BEQEX, S_BNEEX: begin
            alusrca    = 1'b1;
            aluop      = ALUOP_SUB;
            pcsrc      = 2'b01;
            branch     = (state == S_BEQEX);
            branch_ne  = (state == S_BNEEX);
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca    = 1'b1;
            alusrcb    = 2'b10;
            state_next = S_ADDIWB;
         end
         S_ADDIWB: begin
            regwrite_s = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_JEX: begin
            pcsrc      = 2'b10;
            pcwrite    = 1'b1;
            instr_done = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   mips_mc_aludec u_aludec (
      .aluop      (aluop),
      .funct      (funct),
      .alucontrol (alucontrol)
   );

   // enables are gated by reset itself so a write aborts without waiting for an edge
   assign pcen      = reset & (pcwrite | (branch & zero) | (branch_ne & ~zero));
   assign irwrite   = reset & irwrite_s;
   assign regwrite  = reset & regwrite_s;
   assign memwrite  = reset & memwrite_s;
   assign halted    = (state == S_HALT);
   assign state_dbg = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized self-checking bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;
   import mips_mc_pkg::*;

   typedef struct {
      logic        mr;
      logic [20:0] vec;
   } cyc_t;

   logic clk = 1'b0, reset = 1'b0, mem_ready = 1'b0, zero = 1'b0;
   logic [5:0] op = '0, funct = '0;

   logic pcen_h, irwrite_h, regwrite_h, memwrite_h, iord_h, alusrca_h, memtoreg_h, regdst_h;
   logic instr_done_h, halted_h;
   logic [1:0] alusrcb_h, pcsrc_h;
   logic [2:0] alucontrol_h;
   logic [3:0] state_dbg_h;
   logic [31:0] icount_h;

   logic pcen_d, irwrite_d, regwrite_d, memwrite_d, iord_d, alusrca_d, memtoreg_d, regdst_d;
   logic instr_done_d, halted_d;
   logic [1:0] alusrcb_d, pcsrc_d;
   logic [2:0] alucontrol_d;
   logic [3:0] state_dbg_d;
   logic [3:0] icount_d;

   logic [20:0] obs_h, obs_d;
   int vectors = 0, miscompares = 0;
   int unsigned cnt = 0;
   cyc_t trace[$];

   mips_multicycle_ctrl #(.ICOUNT_W(32), .ILLEGAL_HALT(1'b1)) dut (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pcen(pcen_h), .irwrite(irwrite_h), .regwrite(regwrite_h), .memwrite(memwrite_h),
      .iord(iord_h), .alusrca(alusrca_h), .alusrcb(alusrcb_h), .memtoreg(memtoreg_h),
      .regdst(regdst_h), .pcsrc(pcsrc_h), .alucontrol(alucontrol_h), .instr_done(instr_done_h),
      .icount(icount_h), .halted(halted_h), .state_dbg(state_dbg_h)
   );

   mips_multicycle_ctrl #(.ICOUNT_W(4), .ILLEGAL_HALT(1'b0)) dut_nohalt (
      .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .mem_ready(mem_ready),
      .pcen(pcen_d), .irwrite(irwrite_d), .regwrite(regwrite_d), .memwrite(memwrite_d),
      .iord(iord_d), .alusrca(alusrca_d), .alusrcb(alusrcb_d), .memtoreg(memtoreg_d),
      .regdst(regdst_d), .pcsrc(pcsrc_d), .alucontrol(alucontrol_d), .instr_done(instr_done_d),
      .icount(icount_d), .halted(halted_d), .state_dbg(state_dbg_d)
   );

   assign obs_h = {state_dbg_h, pcen_h, irwrite_h, regwrite_h, memwrite_h, iord_h, alusrca_h,
                   alusrcb_h, memtoreg_h, regdst_h, pcsrc_h, alucontrol_h, instr_done_h, halted_h};
   assign obs_d = {state_dbg_d, pcen_d, irwrite_d, regwrite_d, memwrite_d, iord_d, alusrca_d,
                   alusrcb_d, memtoreg_d, regdst_d, pcsrc_d, alucontrol_d, instr_done_d, halted_d};

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   function automatic logic [20:0] v(input logic [3:0] st, input logic pc, ir, rw, mw, io, a,
                                     input logic [1:0] b, input logic mt, rd, input logic [1:0] ps,
                                     input logic [2:0] alu, input logic dn, hl);
      return {st, pc, ir, rw, mw, io, a, b, mt, rd, ps, alu, dn, hl};
   endfunction

   function automatic logic [2:0] funct_alu(input logic [5:0] f);
      logic [2:0] r;
      r = 3'b010;
      if (f == 6'b100010) r = 3'b110;
      if (f == 6'b100100) r = 3'b000;
      if (f == 6'b100101) r = 3'b001;
      if (f == 6'b101010) r = 3'b111;
      return r;
   endfunction

   task automatic push(input logic mr, input logic [20:0] vec);
      trace.push_back('{mr, vec});
   endtask

   task automatic build_front(input int fw);
      trace.delete();
      for (int i = 0; i < fw; i++) push(1'b0, v(0, 0,0,0,0,0,0, 2'b01, 0,0, 2'b00, 3'b010, 0,0));
      push(1'b1, v(0, 1,1,0,0,0,0, 2'b01, 0,0, 2'b00, 3'b010, 0,0));
      push(1'($urandom_range(0,1)), v(1, 0,0,0,0,0,0, 2'b11, 0,0, 2'b00, 3'b010, 0,0));
   endtask

   // expected cycle-by-cycle trace of one legal instruction, derived from the instruction class
   task automatic build(input logic [5:0] o, input logic [5:0] f, input logic z, input int fw, input int mw);
      build_front(fw);
      if (o == 6'b100011 || o == 6'b101011)
         push(1'($urandom_range(0,1)), v(2, 0,0,0,0,0,1, 2'b10, 0,0, 2'b00, 3'b010, 0,0));
      if (o == 6'b100011) begin
         for (int i = 0; i < mw; i++) push(1'b0, v(3, 0,0,0,0,1,0, 2'b00, 0,0, 2'b00, 3'b010, 0,0));
         push(1'b1, v(3, 0,0,0,0,1,0, 2'b00, 0,0, 2'b00, 3'b010, 0,0));
         push(1'($urandom_range(0,1)), v(4, 0,0,1,0,0,0, 2'b00, 1,0, 2'b00, 3'b010, 1,0));
      end else if (o == 6'b101011) begin
         for (int i = 0; i < mw; i++) push(1'b0, v(5, 0,0,0,1,1,0, 2'b00, 0,0, 2'b00, 3'b010, 0,0));
         push(1'b1, v(5, 0,0,0,1,1,0, 2'b00, 0,0, 2'b00, 3'b010, 1,0));
      end else if (o == 6'b000000) begin
         push(1'($urandom_range(0,1)), v(6, 0,0,0,0,0,1, 2'b00, 0,0, 2'b00, funct_alu(f), 0,0));
         push(1'($urandom_range(0,1)), v(7, 0,0,1,0,0,0, 2'b00, 0,1, 2'b00, 3'b010, 1,0));
      end else if (o == 6'b000100) begin
         push(1'($urandom_range(0,1)), v(8, z,0,0,0,0,1, 2'b00, 0,0, 2'b01, 3'b110, 1,0));
      end else if (o == 6'b000101) begin
         push(1'($urandom_range(0,1)), v(12, !z,0,0,0,0,1, 2'b00, 0,0, 2'b01, 3'b110, 1,0));
      end else if (o == 6'b001000) begin
         push(1'($urandom_range(0,1)), v(9, 0,0,0,0,0,1, 2'b10, 0,0, 2'b00, 3'b010, 0,0));
         push(1'($urandom_range(0,1)), v(10, 0,0,1,0,0,0, 2'b00, 0,0, 2'b00, 3'b010, 1,0));
      end else begin
         push(1'($urandom_range(0,1)), v(11, 1,0,0,0,0,0, 2'b00, 0,0, 2'b10, 3'b010, 1,0));
      end
   endtask

   task automatic play(input string tag);
      cyc_t c;
      while (trace.size() > 0) begin
         c = trace.pop_front();
         mem_ready = c.mr;
         @(negedge clk);
         check({tag, "_h"}, 32'(obs_h), 32'(c.vec));
         check({tag, "_d"}, 32'(obs_d), 32'(c.vec));
         @(posedge clk); #1;
      end
   endtask

   task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                            input logic z, input int fw, input int mw);
      op = o; funct = f; zero = z;
      build(o, f, z, fw, mw);
      play(tag);
      cnt++;
      check({tag, "_icount_h"}, icount_h, cnt);
      check({tag, "_icount_d"}, 32'(icount_d), cnt % 16);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      mem_ready = 1'b1;
      #1;
      check({tag, "_h"}, {state_dbg_h, halted_h, irwrite_h, pcen_h, icount_h[27:0]}, 32'h0);
      check({tag, "_d"}, {24'h0, state_dbg_d, halted_d, irwrite_d, pcen_d, 1'b0}, 32'h0);
      check({tag, "_icount_d"}, 32'(icount_d), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      cnt = 0;
   endtask

   logic [5:0] ops[$];
   logic [5:0] fns[$];
   logic [5:0] ill[$];
   logic [5:0] o, f;

   initial begin
      ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010};
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      ill = '{6'b111111};
`ifdef MIPS_MC_BNE_EN
      ops.push_back(6'b000101);
`else
      ill.push_back(6'b000101);
`endif
      repeat (2) @(posedge clk);
      #1;
      do_reset("reset_state");

      run_instr("lw_nowait", 6'b100011, 6'h00, 1'b0, 0, 0);
      run_instr("sw_wait3", 6'b101011, 6'h00, 1'b0, 0, 3);
      run_instr("beq_taken", 6'b000100, 6'h00, 1'b1, 0, 0);
      run_instr("beq_not", 6'b000100, 6'h00, 1'b0, 0, 0);
      run_instr("r_slt", 6'b000000, 6'b101010, 1'b0, 0, 0);
      run_instr("r_badfn", 6'b000000, 6'b111111, 1'b0, 1, 0);
      run_instr("j", 6'b000010, 6'h00, 1'b0, 0, 0);
      run_instr("addi_fw2", 6'b001000, 6'h00, 1'b1, 2, 0);

      for (int n = 0; n < 60; n++) begin
         o = ops[$urandom_range(0, ops.size() - 1)];
         f = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, fns.size() - 1)];
         run_instr("rand", o, f, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2));
      end

      foreach (ill[k]) begin
         op = ill[k];
         build_front(1);
         play("illegal_fd");
         mem_ready = 1'b0;
         @(negedge clk);
         check("nohalt_back_to_fetch", 32'({state_dbg_d, halted_d}), 32'h0);
         check("nohalt_icount", 32'(icount_d), cnt % 16);
         for (int i = 0; i < 20; i++) begin
            mem_ready = 1'($urandom_range(0, 1));
            zero = 1'($urandom_range(0, 1));
            #1;
            check("halt_hold", 32'(obs_h), 32'(v(15, 0,0,0,0,0,0, 2'b00, 0,0, 2'b00, 3'b010, 0,1)));
            @(posedge clk); #1;
            mem_ready = 1'b0;
            @(negedge clk);
         end
         check("halt_icount", icount_h, cnt);
         @(posedge clk); #1;
         do_reset("halt_reset");
         run_instr("post_halt_j", 6'b000010, 6'h00, 1'b0, 0, 0);
      end

      op = 6'b101011; funct = 6'h00;
      build(6'b101011, 6'h00, 1'b0, 0, 0);
      void'(trace.pop_back());
      play("sw_pre_abort");
      mem_ready = 1'b0;
      @(negedge clk);
      check("abort_memwrite_before", 32'({state_dbg_h, memwrite_h, memwrite_d}), 32'h17);
      #2 reset = 1'b0;
      #1;
      check("abort_memwrite_async", 32'({state_dbg_h, memwrite_h, memwrite_d, state_dbg_d}), 32'h0);
      check("abort_icount", icount_h + 32'(icount_d), 32'h0);
      mem_ready = 1'b1;
      @(posedge clk); #1;
      check("reset_hold_no_fetch", 32'({state_dbg_h, irwrite_h, pcen_h, irwrite_d, pcen_d}), 32'h0);
      reset = 1'b1;
      cnt = 0;
      run_instr("post_abort_lw", 6'b100011, 6'h00, 1'b0, 0, 1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
